// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM fade controller.
package pwm_pkg;
  localparam int DUTY_W            = 8;
  localparam int RATE_W            = 8;
  localparam int PERIOD_CYCLES_DEF = 256;

  typedef enum logic [1:0] {IDLE, UP, DOWN, FINISH} fade_state_t;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [RATE_W-1:0] rate_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Command and status bundle between a fade requester and pwm_fade_ctrl.
interface pwm_fade_ctrl_if;
  logic          cmd_valid;
  logic          cmd_ready;
  pwm_pkg::duty_t cmd_target;
  pwm_pkg::rate_t cmd_rate;
  logic          abort;
  pwm_pkg::duty_t duty_cycle;
  logic          period_tick;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_target, cmd_rate, abort,
    input  cmd_ready, duty_cycle, period_tick, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_rate, abort,
    output cmd_ready, duty_cycle, period_tick, busy, done
  );
endinterface

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; period_tick is registered and high on the last count.
module pwm_period_tick import pwm_pkg::*; #(
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);
  localparam int            CW   = cnt_width(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);

  // Tick is decoded from the next count so it lines up with cnt == LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      period_tick <= (cnt_nxt == LAST);
    end
  end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// Ramps a registered PWM duty toward a commanded target, one LSB per (rate+1) periods.
module pwm_fade_ctrl import pwm_pkg::*; #(
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_fade_ctrl_if.slave  bus
);
  fade_state_t state, state_nxt;
  duty_t       duty, duty_nxt, target, target_nxt;
  rate_t       rate, rate_nxt, rate_cnt, rate_cnt_nxt;
  logic        done_q, done_nxt;
  logic        armed;
  logic        tick;
  logic        cmd_ready;

  pwm_period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (tick)
  );

  // armed keeps cmd_ready low through reset and releases it on the first clock after.
  assign cmd_ready       = armed && (state == IDLE) && !bus.abort;
  assign bus.cmd_ready   = cmd_ready;
  assign bus.busy        = (state == UP) || (state == DOWN);
  assign bus.duty_cycle  = duty;
  assign bus.period_tick = tick;
  assign bus.done        = done_q;

  always_comb begin
    state_nxt    = state;
    duty_nxt     = duty;
    target_nxt   = target;
    rate_nxt     = rate;
    rate_cnt_nxt = rate_cnt;
    if (bus.abort) begin
      state_nxt    = IDLE;
      rate_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready) begin
            target_nxt   = bus.cmd_target;
            rate_nxt     = bus.cmd_rate;
            rate_cnt_nxt = '0;
            if (bus.cmd_target > duty)      state_nxt = UP;
            else if (bus.cmd_target < duty) state_nxt = DOWN;
            else                            state_nxt = FINISH;
          end
        end
        UP, DOWN: begin
          // Stepping only on a tick keeps duty stable within a PWM period;
          // reaching the target halts stepping, so the 8-bit value never wraps.
          if (duty == target) begin
            state_nxt = FINISH;
          end else if (tick) begin
            if (rate_cnt == rate) begin
              duty_nxt     = (state == UP) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
              rate_cnt_nxt = '0;
            end else begin
              rate_cnt_nxt = rate_cnt + RATE_W'(1);
            end
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    done_nxt = (state_nxt == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty     <= '0;
      target   <= '0;
      rate     <= '0;
      rate_cnt <= '0;
      done_q   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      target   <= target_nxt;
      rate     <= rate_nxt;
      rate_cnt <= rate_cnt_nxt;
      done_q   <= done_nxt;
      armed    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed and random ramps against a closed-form timing model.
module tb_pwm_fade_ctrl;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   mdl_duty = 0;

  pwm_fade_ctrl_if bus ();

  pwm_fade_ctrl #(.PERIOD_CYCLES(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the period phase of a cycle is n mod P.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command from IDLE. The model: the k-th tick at or after the accept
  // edge a steps the duty once every (rate+1) ticks, a step is visible on the
  // cycle after its tick, FINISH follows one cycle after the target is seen.
  task automatic ramp(input int tgt, input int rate, input bit noise,
                      input int abort_val, input int rst_after);
    int a, s, dir, k, t1, e, ticks, expd, start;
    start = mdl_duty;
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt[7:0];
    bus.cmd_rate   = rate[7:0];
    a   = n + 1;
    s   = (tgt > start) ? tgt - start : start - tgt;
    dir = (tgt > start) ? 1 : -1;
    step();
    bus.cmd_valid = 1'b0;
    if (s == 0) begin
      chk("equal_done", bus.done, 1);
      chk("equal_busy", bus.busy, 0);
      chk("equal_duty", bus.duty_cycle, start);
      step();
      chk("equal_done_end", bus.done, 0);
      chk("equal_ready", bus.cmd_ready, 1);
      return;
    end
    k  = s * (rate + 1);
    t1 = a + (P - 1 - (a % P));
    e  = t1 + (k - 1) * P + 1;
    while (n <= e) begin
      ticks = (n / P) - (a / P);
      expd  = start + dir * ((ticks / (rate + 1) < s) ? ticks / (rate + 1) : s);
      chk("ramp_duty", bus.duty_cycle, expd);
      chk("ramp_busy", bus.busy, 1);
      chk("ramp_done", bus.done, 0);
      chk("ramp_ready", bus.cmd_ready, 0);
      chk("ramp_tick", bus.period_tick, ((n % P) == P - 1) ? 1 : 0);
      if (abort_val >= 0 && expd == abort_val) begin
        bus.abort     = 1'b1;
        bus.cmd_valid = 1'b0;
        step();
        chk("abort_duty", bus.duty_cycle, abort_val);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        bus.abort = 1'b0;
        #1;
        chk("abort_idle_ready", bus.cmd_ready, 1);
        repeat (2 * P) begin
          step();
          chk("abort_hold_duty", bus.duty_cycle, abort_val);
          chk("abort_no_done", bus.done, 0);
        end
        mdl_duty = abort_val;
        return;
      end
      if (rst_after >= 0 && n - a == rst_after) begin
        bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_duty", bus.duty_cycle, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tick", bus.period_tick, 0);
        repeat (3) begin
          step();
          chk("rst_hold_duty", bus.duty_cycle, 0);
          chk("rst_hold_done", bus.done, 0);
          chk("rst_hold_ready", bus.cmd_ready, 0);
        end
        rst_n = 1'b1;
        step();
        chk("rst_release_ready", bus.cmd_ready, 1);
        chk("rst_release_duty", bus.duty_cycle, 0);
        chk("rst_release_done", bus.done, 0);
        mdl_duty = 0;
        return;
      end
      if (noise) begin
        bus.cmd_valid  = 1'($urandom_range(0, 1));
        bus.cmd_target = 8'($urandom_range(0, 255));
        bus.cmd_rate   = 8'($urandom_range(0, 255));
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("finish_done", bus.done, 1);
    chk("finish_busy", bus.busy, 0);
    chk("finish_duty", bus.duty_cycle, tgt);
    step();
    chk("idle_done", bus.done, 0);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_duty", bus.duty_cycle, tgt);
    mdl_duty = tgt;
  endtask

  initial begin
    int tgt, rate;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_rate   = '0;
    bus.abort      = 1'b0;

    // Reset state with the clock running.
    repeat (3) step();
    chk("reset_duty", bus.duty_cycle, 0);
    chk("reset_ready", bus.cmd_ready, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_tick", bus.period_tick, 0);
    rst_n = 1'b1;
    step();
    chk("release_ready", bus.cmd_ready, 1);

    ramp(3, 0, 1'b0, -1, -1);   // basic up ramp 0 -> 3
    ramp(3, 0, 1'b0, -1, -1);   // equal target
    ramp(5, 0, 1'b0, -1, -1);
    ramp(2, 2, 1'b0, -1, -1);   // down ramp 5 -> 2, one step per 3 ticks
    ramp(0, 0, 1'b0, -1, -1);
    ramp(20, 0, 1'b0, 7, -1);   // abort at duty 7

    // Abort and command together in IDLE: abort wins.
    bus.abort      = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 8'd200;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("abort_cmd_busy", bus.busy, 0);
    chk("abort_cmd_done", bus.done, 0);
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("abort_cmd_ready_after", bus.cmd_ready, 1);
    repeat (P + 1) begin
      step();
      chk("abort_cmd_duty", bus.duty_cycle, mdl_duty);
      chk("abort_cmd_no_busy", bus.busy, 0);
    end

    ramp(255, 0, 1'b1, -1, -1); // endpoint with ignored commands mid-ramp
    repeat (2 * P) begin
      step();
      chk("top_hold", bus.duty_cycle, 255);
    end

    for (int i = 0; i < 4; i++) begin
      tgt  = $urandom_range(0, 255);
      rate = $urandom_range(0, 2);
      ramp(tgt, rate, 1'b1, -1, -1);
    end

    if (mdl_duty > 200) ramp(100, 0, 1'b0, -1, -1);
    ramp(255, 0, 1'b0, -1, 17);  // reset mid-ramp
    ramp(2, 0, 1'b0, -1, -1);    // block works normally after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
